// File: rtl/conv_window_gen_3x3.sv
// 3x3 sliding-window generator: two line buffers plus a two-column register window
// turn a raster pixel stream into valid (unpadded) 3x3 neighbourhoods, one cycle after acceptance.
module conv_window_gen_3x3 #(
    parameter int unsigned IMG_W  = 7,
    parameter int unsigned IMG_H  = 7,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] In_Pixel,
    output logic              out_valid,
    output logic [DATA_W-1:0] Out_IFM_1,
    output logic [DATA_W-1:0] Out_IFM_2,
    output logic [DATA_W-1:0] Out_IFM_3,
    output logic [DATA_W-1:0] Out_IFM_4,
    output logic [DATA_W-1:0] Out_IFM_5,
    output logic [DATA_W-1:0] Out_IFM_6,
    output logic [DATA_W-1:0] Out_IFM_7,
    output logic [DATA_W-1:0] Out_IFM_8,
    output logic [DATA_W-1:0] Out_IFM_9,
    output logic              frame_done
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [DATA_W-1:0] lb1_q [IMG_W];   // row r-1
    logic [DATA_W-1:0] lb1_d [IMG_W];
    logic [DATA_W-1:0] lb2_q [IMG_W];   // row r-2
    logic [DATA_W-1:0] lb2_d [IMG_W];
    logic [DATA_W-1:0] win_q [3][2];    // [row top..bottom][col c-2, c-1]
    logic [DATA_W-1:0] win_d [3][2];
    logic [DATA_W-1:0] out_q [9];
    logic [DATA_W-1:0] out_d [9];
    logic              out_valid_q, out_valid_d;
    logic              frame_done_q, frame_done_d;

    logic [DATA_W-1:0] new_col [3];
    logic              col_last, row_last;

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        lb1_d        = lb1_q;
        lb2_d        = lb2_q;
        win_d        = win_q;
        out_d        = out_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;

        col_last   = (col_q == CW'(IMG_W - 1));
        row_last   = (row_q == RW'(IMG_H - 1));
        new_col[0] = lb2_q[col_q];
        new_col[1] = lb1_q[col_q];
        new_col[2] = In_Pixel;

        if (in_valid) begin
            lb2_d[col_q] = lb1_q[col_q];
            lb1_d[col_q] = In_Pixel;
            for (int i = 0; i < 3; i++) begin
                win_d[i][0] = win_q[i][1];
                win_d[i][1] = new_col[i];
            end

            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end

            unique case (state_q)
                IDLE:    state_d = FILL;
                FILL:    if (col_last && (row_q == RW'(1))) state_d = RUN;
                RUN:     if (col_last && row_last) state_d = IDLE;
                default: state_d = IDLE;
            endcase

            // RUN implies row >= 2, so stale previous-frame rows never reach the output
            if ((state_q == RUN) && (col_q >= CW'(2))) begin
                out_valid_d  = 1'b1;
                frame_done_d = col_last && row_last;
                for (int i = 0; i < 3; i++) begin
                    out_d[3*i]     = win_q[i][0];
                    out_d[3*i + 1] = win_q[i][1];
                    out_d[3*i + 2] = new_col[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < int'(IMG_W); i++) begin
                lb1_q[i] <= '0;
                lb2_q[i] <= '0;
            end
            for (int i = 0; i < 3; i++) begin
                win_q[i][0] <= '0;
                win_q[i][1] <= '0;
            end
            for (int i = 0; i < 9; i++) out_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            lb1_q        <= lb1_d;
            lb2_q        <= lb2_d;
            win_q        <= win_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign Out_IFM_1  = out_q[0];
    assign Out_IFM_2  = out_q[1];
    assign Out_IFM_3  = out_q[2];
    assign Out_IFM_4  = out_q[3];
    assign Out_IFM_5  = out_q[4];
    assign Out_IFM_6  = out_q[5];
    assign Out_IFM_7  = out_q[6];
    assign Out_IFM_8  = out_q[7];
    assign Out_IFM_9  = out_q[8];

endmodule

// File: tb/tb_conv_window_gen_3x3.sv
// Directed bench for conv_window_gen_3x3: nominal, stalls, back-to-back, mid-frame reset
// on a 7x7 instance, plus a 5x4 instance for the parameter sweep.
module tb_conv_window_gen_3x3;

    localparam int unsigned W  = 7;
    localparam int unsigned H  = 7;
    localparam int unsigned SW = 5;
    localparam int unsigned SH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_pixel = '0;
    logic       out_valid, frame_done;
    logic [7:0] o1, o2, o3, o4, o5, o6, o7, o8, o9;

    logic       iv_s = 1'b0;
    logic [7:0] pix_s = '0;
    logic       ov_s, fd_s;
    logic [7:0] s1, s2, s3, s4, s5, s6, s7, s8, s9;

    int errors = 0;
    int checks = 0;

    logic [72:0] winq [$];      // {frame_done, Out_IFM_1..9}
    logic        acc_q = 1'b0;
    logic [7:0]  last_pix = '0;
    int          cnt_s = 0;
    logic [71:0] first_s = '0;

    always #5 clk = ~clk;

    conv_window_gen_3x3 #(.IMG_W(W), .IMG_H(H), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .In_Pixel(in_pixel),
        .out_valid(out_valid),
        .Out_IFM_1(o1), .Out_IFM_2(o2), .Out_IFM_3(o3),
        .Out_IFM_4(o4), .Out_IFM_5(o5), .Out_IFM_6(o6),
        .Out_IFM_7(o7), .Out_IFM_8(o8), .Out_IFM_9(o9),
        .frame_done(frame_done)
    );

    conv_window_gen_3x3 #(.IMG_W(SW), .IMG_H(SH), .DATA_W(8)) dut_s (
        .clk(clk), .rst(rst), .in_valid(iv_s), .In_Pixel(pix_s),
        .out_valid(ov_s),
        .Out_IFM_1(s1), .Out_IFM_2(s2), .Out_IFM_3(s3),
        .Out_IFM_4(s4), .Out_IFM_5(s5), .Out_IFM_6(s6),
        .Out_IFM_7(s7), .Out_IFM_8(s8), .Out_IFM_9(s9),
        .frame_done(fd_s)
    );

    task automatic check(input string tag, input logic [72:0] got, input logic [72:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] pack9(input int a, b, c, d, e, f, g, h, i);
        return {8'(a), 8'(b), 8'(c), 8'(d), 8'(e), 8'(f), 8'(g), 8'(h), 8'(i)};
    endfunction

    // Expected window whose bottom-right pixel is (r,c) for pixel value base + r*w + c
    function automatic logic [71:0] exp_win(input int base, input int w, input int r, input int c);
        logic [71:0] v = '0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                v = {v[63:0], 8'(base + (r - 2 + dr) * w + (c - 2 + dc))};
        return v;
    endfunction

    always @(posedge clk) begin
        acc_q <= in_valid;
        if (in_valid) last_pix <= in_pixel;
    end

    // Every window must follow an accepted pixel and end in that pixel
    always @(negedge clk) begin
        if (out_valid && !rst) begin
            winq.push_back({frame_done, o1, o2, o3, o4, o5, o6, o7, o8, o9});
            check("valid_after_accept", 73'(acc_q), 73'(1));
            check("latency_bottom_right", 73'(o9), 73'(last_pix));
        end
        if (ov_s && !rst) begin
            cnt_s++;
            if (cnt_s == 1) first_s = {s1, s2, s3, s4, s5, s6, s7, s8, s9};
        end
    end

    task automatic stream(input int base, input int npix, input bit stall);
        for (int p = 0; p < npix; p++) begin
            in_valid = 1'b1;
            in_pixel = 8'(base + p);
            @(posedge clk); #1;
            if (stall) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic check_frame(input int base, input int k0, input string name);
        int k = k0;
        for (int r = 2; r < int'(H); r++)
            for (int c = 2; c < int'(W); c++) begin
                if (k < winq.size()) begin
                    check($sformatf("%s_win%0d", name, k), 73'(winq[k][71:0]), 73'(exp_win(base, W, r, c)));
                    check($sformatf("%s_fd%0d", name, k), 73'(winq[k][72]),
                          73'((r == int'(H) - 1) && (c == int'(W) - 1)));
                end
                k++;
            end
    endtask

    task automatic nominal_checks(input string name);
        check({name, "_count"}, 73'(winq.size()), 73'(25));
        if (winq.size() == 25) begin
            check({name, "_first"}, 73'(winq[0][71:0]), 73'(pack9(0, 1, 2, 7, 8, 9, 14, 15, 16)));
            check({name, "_rowwrap"}, 73'(winq[5][71:0]), 73'(pack9(7, 8, 9, 14, 15, 16, 21, 22, 23)));
            check({name, "_last"}, winq[24], {1'b1, pack9(32, 33, 34, 39, 40, 41, 46, 47, 48)});
            check_frame(0, 0, name);
        end
    endtask

    initial begin
        int fd_cnt;

        rst = 1'b1;
        #12;
        check("reset_valid", 73'(out_valid), 73'(0));
        check("reset_fd", 73'(frame_done), 73'(0));
        check("reset_data", 73'({o1, o2, o3, o4, o5, o6, o7, o8, o9}), 73'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Nominal gapless frame
        winq.delete();
        stream(0, 49, 1'b0);
        repeat (3) @(posedge clk); #1;
        nominal_checks("nom");

        // Same frame with random stalls
        winq.delete();
        stream(0, 49, 1'b1);
        repeat (3) @(posedge clk); #1;
        nominal_checks("stall");

        // Back-to-back frames, second offset by 100
        winq.delete();
        stream(0, 49, 1'b0);
        stream(100, 49, 1'b0);
        repeat (3) @(posedge clk); #1;
        check("b2b_count", 73'(winq.size()), 73'(50));
        fd_cnt = 0;
        foreach (winq[i]) if (winq[i][72]) fd_cnt++;
        check("b2b_fd_pulses", 73'(fd_cnt), 73'(2));
        if (winq.size() == 50) begin
            check("b2b_f2_first", 73'(winq[25][71:0]), 73'(pack9(100, 101, 102, 107, 108, 109, 114, 115, 116)));
            check_frame(0, 0, "b2b1");
            check_frame(100, 25, "b2b2");
        end

        // Asynchronous reset mid-frame, while the last window is still on the outputs
        winq.delete();
        stream(0, 20, 1'b0);
        check("pre_rst_valid", 73'(out_valid), 73'(1));
        #2 rst = 1'b1;
        #1;
        check("rst_async_valid", 73'(out_valid), 73'(0));
        check("rst_async_fd", 73'(frame_done), 73'(0));
        check("rst_async_data", 73'({o1, o2, o3, o4, o5, o6, o7, o8, o9}), 73'(0));
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        winq.delete();
        stream(0, 49, 1'b0);
        repeat (3) @(posedge clk); #1;
        nominal_checks("post_rst");

        // 5x4 instance
        for (int p = 0; p < int'(SW * SH); p++) begin
            iv_s  = 1'b1;
            pix_s = 8'(p);
            @(posedge clk); #1;
        end
        iv_s = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("small_count", 73'(cnt_s), 73'(6));
        check("small_first", 73'(first_s), 73'(pack9(0, 1, 2, 5, 6, 7, 10, 11, 12)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_window_gen_3x3.md
Name: conv_window_gen_3x3

Overview:
- Upstream feeder for the 3x3 pipelined convolution stage.
- Accepts a raster-order pixel stream, one pixel per accepted cycle.
- Buffers two full lines plus a 3x3 register window.
- Presents every valid (no-padding) 3x3 neighbourhood as nine parallel pixels with a valid strobe. These outputs drive the convolution stage's In_IFM_1..9 and in_valid directly.

Parameters:
- IMG_W, 7, frame width in pixels (>=3).
- IMG_H, 7, frame height in pixels (>=3).
- DATA_W, 8, pixel width in bits.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  In_Pixel is accepted on this cycle.
- In_Pixel  input  DATA_W  pixel, raster order (row 0 col 0 first).
- out_valid  output  1  Out_IFM_1..9 hold a new window this cycle.
- Out_IFM_1 .. Out_IFM_9  output  DATA_W each  window, row-major: 1..3 top row, 4..6 middle, 7..9 bottom; 1/4/7 leftmost column.
- frame_done  output  1  one-cycle pulse coincident with the last window of a frame.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is asynchronous and active-high.
- All outputs are registered. Reset values: out_valid=0, frame_done=0, Out_IFM_1..9=0.
- Reset also clears the column/row counters, state, line buffers and window registers.
- Counters:
  - col counts 0..IMG_W-1 and row counts 0..IMG_H-1; both advance only on in_valid.
  - col wraps to 0 and row increments at col=IMG_W-1.
  - Both wrap to 0 at the last pixel of the frame.
- Line buffers: two buffers of IMG_W entries, written on in_valid. They hold rows r-1 and r-2 at the current column. The window shifts left by one column per accepted pixel.
- Emission rule: when a pixel at (r,c) is accepted with r>=2 and c>=2, the next cycle has:
  - out_valid=1;
  - Out_IFM_1..9 = pixels (r-2,c-2),(r-2,c-1),(r-2,c),(r-1,c-2),(r-1,c-1),(r-1,c),(r,c-2),(r,c-1),(r,c).
  - Latency from pixel acceptance to window is 1 cycle.
- No window is emitted for c<2 or r<2. Windows never straddle row boundaries.
- Windows per frame: (IMG_W-2)*(IMG_H-2), which is 25 for the defaults.
- When out_valid=0, Out_IFM_1..9 hold their last values. Downstream samples only on out_valid.
- frame_done=1 in the same cycle as the window for (IMG_H-1,IMG_W-1); otherwise 0.
- State machine (state updates on accepted pixels):
  - IDLE: no pixel of the current frame accepted yet. On in_valid go to FILL.
  - FILL: row<2. Go to RUN when the pixel (1,IMG_W-1) is accepted.
  - RUN: row>=2, windows are emitted. Go to IDLE when the pixel (IMG_H-1,IMG_W-1) is accepted.
- Stalls: in_valid may drop for any number of cycles mid-frame. State, counters and buffers freeze. Output is identical to a gapless stream except for timing.
- Back-to-back frames: a pixel on the cycle after the last pixel of a frame is row 0 col 0 of the next frame. No bubble is required.
- Stale data: line-buffer contents from a previous frame are never emitted, because emission requires r>=2 in the current frame.
- Reset mid-frame: everything returns to reset values on assertion, regardless of the clock. The first pixel after deassertion is (0,0).
- No backpressure: the downstream stage always accepts.

Test Plan:
- Nominal 7x7, pixel p=r*7+c (0..48), in_valid held high:
  - first out_valid is one cycle after pixel 16, with Out_IFM_1..9 = 0,1,2,7,8,9,14,15,16;
  - exactly 25 out_valid pulses;
  - last window is 32,33,34,39,40,41,46,47,48 with frame_done=1 on that cycle only.
- Row wrap, same frame: pixels 21 and 22 produce no out_valid. Pixel 23 yields 7,8,9,14,15,16,21,22,23.
- Stalls, same frame with in_valid low for 1 to 3 random cycles between pixels: the same 25 windows appear in the same order, and out_valid never asserts during a gap.
- Back-to-back frames, frame 1 as above then frame 2 with p+100 and no gap:
  - frame 2's first window is 100,101,102,107,108,109,114,115,116;
  - no window contains frame-1 data;
  - frame_done pulses twice.
- Reset mid-frame, rst asserted after 20 pixels:
  - out_valid, frame_done and Out_IFM_1..9 go to 0 immediately;
  - a fresh frame after deassertion reproduces the nominal results exactly.
- Parameter sweep IMG_W=5, IMG_H=4, pixel p=r*5+c: 6 windows, the first being 0,1,2,5,6,7,10,11,12.
